// File: rtl/biss_pkg.sv
// Shared BiSS-C definitions: frame states, CRC polynomial and field widths.
// Used by the slave transmitter and reusable by a master receiver.
package biss_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_ARM,
    ST_ACK,
    ST_START,
    ST_CDS,
    ST_DATA,
    ST_CRC,
    ST_TIMEOUT
  } biss_state_t;

  localparam logic [6:0] CRC_POLY = 7'b1000011;

  localparam int POS_W        = 26;
  localparam int CRC_W        = 6;
  localparam int FRAME_DATA_W = 28;

endpackage

// File: rtl/biss_crc6.sv
// Serial CRC-6 (x^6+x+1), init 0, non-inverted, one bit per enabled clk.
// Feeding data then its CRC through this leaves a zero remainder.
import biss_pkg::*;

module biss_crc6 (
  input  logic             clk,
  input  logic             rst,
  input  logic             clear,
  input  logic             en,
  input  logic             din,
  output logic [CRC_W-1:0] crc
);

  logic [CRC_W-1:0] r_crc;
  logic             w_fb;

  assign w_fb = din ^ r_crc[CRC_W-1];
  assign crc  = r_crc;

  always_ff @(posedge clk) begin
    if (rst || clear) begin
      r_crc <= '0;
    end else if (en) begin
      r_crc <= {r_crc[CRC_W-2:0], 1'b0}
             ^ (w_fb ? CRC_POLY[CRC_W-1:0] : '0);
    end
  end

endmodule

// File: rtl/biss_slave_tx.sv
// BiSS-C slave transmitter: ACK, start, CDS, 28 data bits, CRC-6, timeout.
// Optional BISS_SLAVE_CRC_ERR_INJ_EN adds crc_err_inj to flip the CRC LSB.
import biss_pkg::*;

module biss_slave_tx #(
  parameter int ACK_CYCLES   = 2,
  parameter int TIMEOUT_CLKS = 1000
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             ma,
  input  logic [POS_W-1:0] pos_data,
  input  logic             err_n,
  input  logic             warn_n,
`ifdef BISS_SLAVE_CRC_ERR_INJ_EN
  input  logic             crc_err_inj,
`endif
  output logic             sl,
  output logic             busy,
  output logic             frame_done
);

  localparam int TW = (TIMEOUT_CLKS > 1) ? $clog2(TIMEOUT_CLKS) : 1;
  localparam int DW = FRAME_DATA_W;

  biss_state_t     r_state, w_nxt;
  logic            r_ma_s1, r_ma_s2, r_ma_d;
  logic [DW-1:0]   r_sh, w_sh;
  logic [5:0]      r_bcnt, w_bcnt;
  logic [3:0]      r_acnt, w_acnt;
  logic [TW-1:0]   r_to_cnt;
  logic            r_sl, w_sl;
  logic            r_fd, w_fd;
  logic            w_rise, w_fall, w_to_hit, w_to_clr;
  logic            w_crc_clr, w_crc_en;
  logic [CRC_W-1:0] w_crc, w_crc_tx;
  logic            w_latch;

  assign w_rise   = r_ma_s2 & ~r_ma_d;
  assign w_fall   = ~r_ma_s2 & r_ma_d;
  assign busy     = (r_state != ST_IDLE) && (r_state != ST_ARM);
  assign w_to_hit = r_ma_s2 && busy
                 && (r_to_cnt == TW'(TIMEOUT_CLKS - 1));
  assign w_to_clr = (w_nxt != r_state);
  assign w_latch  = (r_state == ST_ARM) && w_rise;
  assign sl         = r_sl;
  assign frame_done = r_fd;

`ifdef BISS_SLAVE_CRC_ERR_INJ_EN
  logic r_inj;
  always_ff @(posedge clk) begin
    if (rst)          r_inj <= 1'b0;
    else if (w_latch) r_inj <= crc_err_inj;
  end
  assign w_crc_tx = w_crc ^ {{(CRC_W-1){1'b0}}, r_inj};
`else
  assign w_crc_tx = w_crc;
`endif

  biss_crc6 u_crc (
    .clk   (clk),
    .rst   (rst),
    .clear (w_crc_clr),
    .en    (w_crc_en),
    .din   (r_sh[DW-1]),
    .crc   (w_crc)
  );

  always_comb begin
    w_nxt     = r_state;
    w_sl      = r_sl;
    w_sh      = r_sh;
    w_bcnt    = r_bcnt;
    w_acnt    = r_acnt;
    w_fd      = 1'b0;
    w_crc_clr = 1'b0;
    w_crc_en  = 1'b0;
    unique case (r_state)
      ST_IDLE: begin
        w_sl = 1'b1;
        if (w_fall) w_nxt = ST_ARM;
      end
      ST_ARM: begin
        w_sl = 1'b1;
        if (w_rise) begin
          w_nxt     = ST_ACK;
          w_sl      = 1'b0;
          w_sh      = {pos_data, err_n, warn_n};
          w_acnt    = 4'd1;
          w_crc_clr = 1'b1;
        end
      end
      ST_ACK: if (w_rise) begin
        if (r_acnt == 4'(ACK_CYCLES)) begin
          w_nxt = ST_START;
          w_sl  = 1'b1;
        end else begin
          w_acnt = r_acnt + 4'd1;
          w_sl   = 1'b0;
        end
      end
      ST_START: if (w_rise) begin
        w_nxt = ST_CDS;
        w_sl  = 1'b0;
      end
      ST_CDS: if (w_rise) begin
        w_nxt    = ST_DATA;
        w_sl     = r_sh[DW-1];
        w_sh     = {r_sh[DW-2:0], 1'b0};
        w_crc_en = 1'b1;
        w_bcnt   = 6'd1;
      end
      ST_DATA: if (w_rise) begin
        if (r_bcnt == 6'(DW)) begin
          w_nxt  = ST_CRC;
          w_sl   = w_crc_tx[CRC_W-1];
          w_sh   = {w_crc_tx[CRC_W-2:0], {(DW-CRC_W+1){1'b0}}};
          w_bcnt = 6'd1;
        end else begin
          w_sl     = r_sh[DW-1];
          w_sh     = {r_sh[DW-2:0], 1'b0};
          w_crc_en = 1'b1;
          w_bcnt   = r_bcnt + 6'd1;
        end
      end
      ST_CRC: if (w_rise) begin
        if (r_bcnt == 6'(CRC_W)) begin
          w_nxt = ST_TIMEOUT;
          w_sl  = 1'b0;
          w_fd  = 1'b1;
        end else begin
          w_sl   = r_sh[DW-1];
          w_sh   = {r_sh[DW-2:0], 1'b0};
          w_bcnt = r_bcnt + 6'd1;
        end
      end
      ST_TIMEOUT: begin
        w_sl = 1'b0;
        if (w_to_hit) begin
          w_nxt = ST_IDLE;
          w_sl  = 1'b1;
        end
      end
      default: begin
        w_nxt = ST_IDLE;
        w_sl  = 1'b1;
      end
    endcase
    // MA stuck high mid-frame: abandon the frame without frame_done
    if (w_to_hit && r_state != ST_TIMEOUT) begin
      w_nxt = ST_TIMEOUT;
      w_sl  = 1'b0;
      w_fd  = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_ma_s1 <= 1'b1;
      r_ma_s2 <= 1'b1;
      r_ma_d  <= 1'b1;
      r_state <= ST_IDLE;
      r_sh    <= '0;
      r_bcnt  <= '0;
      r_acnt  <= '0;
      r_sl    <= 1'b1;
      r_fd    <= 1'b0;
    end else begin
      r_ma_s1 <= ma;
      r_ma_s2 <= r_ma_s1;
      r_ma_d  <= r_ma_s2;
      r_state <= w_nxt;
      r_sh    <= w_sh;
      r_bcnt  <= w_bcnt;
      r_acnt  <= w_acnt;
      r_sl    <= w_sl;
      r_fd    <= w_fd;
    end
  end

  always_ff @(posedge clk) begin
    if (rst || w_to_clr || !r_ma_s2 || !busy) r_to_cnt <= '0;
    else                                      r_to_cnt <= r_to_cnt + 1'b1;
  end

endmodule

// File: tb/tb_biss_slave_tx.sv
// Directed bench for biss_slave_tx: frames at 1 MHz MA, timeout, abort, reset.
// Build with BISS_SLAVE_CRC_ERR_INJ_EN to exercise the CRC error injection.
module tb_biss_slave_tx;

  logic        clk;
  logic        rst;
  logic        ma;
  logic [25:0] pos;
  logic        err_n;
  logic        warn_n;
  logic        inj;
  logic        sl;
  logic        busy;
  logic        frame_done;

  int n_cmp  = 0;
  int n_err  = 0;
  int fd_cnt = 0;

  biss_slave_tx #(
    .ACK_CYCLES   (2),
    .TIMEOUT_CLKS (1000)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .ma         (ma),
    .pos_data   (pos),
    .err_n      (err_n),
    .warn_n     (warn_n),
`ifdef BISS_SLAVE_CRC_ERR_INJ_EN
    .crc_err_inj(inj),
`endif
    .sl         (sl),
    .busy       (busy),
    .frame_done (frame_done)
  );

  initial clk = 1'b0;
  always #10 clk = ~clk;

  always @(posedge clk)
    if (frame_done === 1'b1) fd_cnt <= fd_cnt + 1;

  task automatic chk(input string tag, input logic [63:0] obs,
                     input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // One MA fall then n rises at 1 MHz; sl sampled 10 clk after each rise.
  task automatic mk_frame(input int n, input bit lat, input int chg_i,
                          input logic [25:0] chg_pos,
                          output logic [63:0] v);
    v  = '0;
    ma = 1'b0;
    repeat (25) @(negedge clk);
    for (int i = 0; i < n; i++) begin
      ma = 1'b1;
      if (lat && i == 0) begin
        @(negedge clk);
        @(negedge clk);
        chk("lat_pre", 64'(sl), 64'd1);
        @(negedge clk);
        chk("lat_post", 64'(sl), 64'd0);
        repeat (7) @(negedge clk);
      end else begin
        repeat (10) @(negedge clk);
      end
      v[i] = sl;
      if (i == chg_i) begin
        pos    = chg_pos;
        err_n  = 1'b0;
        warn_n = 1'b0;
      end
      repeat (15) @(negedge clk);
      if (i != n - 1) begin
        ma = 1'b0;
        repeat (25) @(negedge clk);
      end
    end
  endtask

  task automatic wait_idle(input string tag, input int max);
    bit ok = 1'b0;
    for (int k = 0; k < max && !ok; k++) begin
      @(negedge clk);
      if (busy === 1'b0 && sl === 1'b1) ok = 1'b1;
    end
    chk(tag, 64'(ok), 64'd1);
  endtask

  function automatic logic [27:0] get_word(input logic [63:0] v);
    logic [27:0] w = '0;
    for (int k = 0; k < 28; k++) w = {w[26:0], v[4+k]};
    return w;
  endfunction

  function automatic logic [5:0] get_crc(input logic [63:0] v);
    logic [5:0] c = '0;
    for (int k = 0; k < 6; k++) c = {c[4:0], v[32+k]};
    return c;
  endfunction

  // Master-side check: remainder over data followed by CRC
  function automatic logic [5:0] rem34(input logic [27:0] d,
                                       input logic [5:0] c);
    logic [33:0] b = {d, c};
    logic [5:0]  r = '0;
    logic        fb;
    for (int i = 33; i >= 0; i--) begin
      fb = b[i] ^ r[5];
      r  = {r[4:0], 1'b0} ^ (fb ? 6'b000011 : 6'b000000);
    end
    return r;
  endfunction

  logic [63:0] v;
  int          fd0;

  initial begin
    rst    = 1'b1;
    ma     = 1'b1;
    pos    = '0;
    err_n  = 1'b0;
    warn_n = 1'b0;
    inj    = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_sl", 64'(sl), 64'd1);
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_fd", 64'(frame_done), 64'd0);
    rst = 1'b0;
    repeat (5) @(negedge clk);

    // all-zero frame, with latency check on the first rise
    fd0 = fd_cnt;
    mk_frame(39, 1'b1, -1, '0, v);
    chk("z_ack", 64'(v[1:0]), 64'd0);
    chk("z_start_cds", 64'(v[3:2]), 64'b01);
    chk("z_data", 64'(get_word(v)), 64'd0);
    chk("z_crc", 64'(get_crc(v)), 64'd0);
    chk("z_to_sl", 64'(v[38]), 64'd0);
    chk("z_to_busy", 64'(busy), 64'd1);
    chk("z_fd", 64'(fd_cnt - fd0), 64'd1);
    // MA fall inside TIMEOUT must not start a new frame
    repeat (75) @(negedge clk);
    ma = 1'b0;
    repeat (25) @(negedge clk);
    ma = 1'b1;
    repeat (100) @(negedge clk);
    chk("to_fall_busy", 64'(busy), 64'd1);
    chk("to_fall_sl", 64'(sl), 64'd0);
    wait_idle("z_idle", 2000);

    // warn_n=1 only: last data bit 1, CRC 000011
    warn_n = 1'b1;
`ifdef BISS_SLAVE_CRC_ERR_INJ_EN
    inj = 1'b1;
`endif
    mk_frame(39, 1'b0, -1, '0, v);
    chk("w_data", 64'(get_word(v)), 64'd1);
`ifdef BISS_SLAVE_CRC_ERR_INJ_EN
    chk("w_crc_inj", 64'(get_crc(v)), 64'b000010);
    inj = 1'b0;
`else
    chk("w_crc", 64'(get_crc(v)), 64'b000011);
    chk("w_rem", 64'(rem34(get_word(v), get_crc(v))), 64'd0);
`endif
    wait_idle("w_idle", 2000);

    // inputs change mid-frame; latched word must be transmitted
    pos    = 26'h3FFFFFF;
    err_n  = 1'b1;
    warn_n = 1'b1;
    mk_frame(39, 1'b0, 10, 26'h0, v);
    chk("m_data", 64'(get_word(v)), 64'hFFFFFFF);
    chk("m_rem", 64'(rem34(get_word(v), get_crc(v))), 64'd0);
    wait_idle("m_idle", 2000);

    // MA stops high after 10 data bits: abort, no frame_done
    pos    = 26'h2AAAAAA;
    err_n  = 1'b1;
    warn_n = 1'b1;
    fd0    = fd_cnt;
    mk_frame(14, 1'b0, -1, '0, v);
    chk("a_bits", 64'(v[13:4]), 64'b0101010101);
    repeat (1100) @(negedge clk);
    chk("a_to_sl", 64'(sl), 64'd0);
    chk("a_to_busy", 64'(busy), 64'd1);
    wait_idle("a_idle", 2000);
    chk("a_no_fd", 64'(fd_cnt - fd0), 64'd0);

    // reset during CRC, then a clean frame
    pos    = 26'h123456;
    fd0    = fd_cnt;
    mk_frame(34, 1'b0, -1, '0, v);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("r_sl", 64'(sl), 64'd1);
    chk("r_busy", 64'(busy), 64'd0);
    repeat (10) @(negedge clk);
    pos    = 26'h155AA33;
    err_n  = 1'b0;
    warn_n = 1'b1;
    mk_frame(39, 1'b0, -1, '0, v);
    chk("r_data", 64'(get_word(v)), 64'({26'h155AA33, 2'b01}));
    chk("r_rem", 64'(rem34(get_word(v), get_crc(v))), 64'd0);
    chk("r_fd", 64'(fd_cnt - fd0), 64'd1);
    wait_idle("r_idle", 2000);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
